semafor_directie_param: RTL and testbench
=========================================

// Module: semafor_directie_param
// PURPOSE
//  Parametrised one-approach traffic-light controller for the token-ring intersection.
//  It waits for the token (Continuare) from the previous approach.
//  It then runs a clearance/yellow/green phase sequence and passes the token on with a one-cycle pulse.
//  It adds an internal tick prescaler, parametrised phase durations, pending-token latching,
//  a start-with-token option and a blinking-yellow maintenance mode.
// PARAMETERS
//  SEC       24'd10000000  clk cycles per 1-second tick (>=2)
//  CNT_W     8             width of phase timer; durations 1..2**CNT_W-1
//  T_GARDA   1             all-red clearance ticks after token accepted
//  T_GALBEN  2             yellow ticks
//  T_VERDE   26            green ticks
//  T_BLINK   1             maintenance half-period in ticks
//  HAS_TOKEN 0             1: token considered pending after reset (ring starter)
// PORTS
//  clk            in   1  system clock, single clock domain
//  reset          in   1  asynchronous, active-low reset
//  intretinere    in   1  maintenance request, level, synchronous to clk
//  continuare_in  in   1  token from previous approach; rising edge = token
//  continuare_out out  1  token to next approach, 1-cycle pulse
//  verde          out  1  green lamp
//  galben         out  1  yellow lamp
//  rosu           out  1  red lamp
// BEHAVIOUR
//  - Reset (reset=0, async):
//    - state=ASTEAPTA; rosu=1, verde=galben=continuare_out=0.
//    - prescaler=0, timer=0, prev_in=0, pending=HAS_TOKEN.
//  - All outputs registered; they reflect the state one cycle after entry.
//  - Prescaler:
//    - Counts 0..SEC-1, wraps to 0; tick=1 on the cycle where count==SEC-1.
//    - Prescaler and timer clear on every state change.
//    - Each timed state therefore lasts exactly DUR*SEC cycles.
//  - Token edge:
//    - prev_in registers continuare_in; edge = continuare_in & ~prev_in.
//    - edge sets pending in any state except INTRETINERE; edges during INTRETINERE are dropped.
//  - Durations: a DUR parameter of 0 is treated as 1. Leave a timed state when tick && timer==DUR-1;
//    otherwise timer+=1 on tick.
//  - FSM states (lamps r/y/g):
//    - ASTEAPTA (1/0/0): pending=1 -> GARDA, clear pending in the same cycle.
//      An edge arriving in that cycle re-sets pending (set wins over clear).
//    - GARDA (1/0/0): T_GARDA ticks -> GALBEN.
//    - GALBEN (0/1/0): T_GALBEN ticks -> VERDE.
//    - VERDE (0/0/1): T_VERDE ticks -> PREDARE.
//    - PREDARE (1/0/0): continuare_out=1 for exactly this one cycle -> ASTEAPTA.
//    - INTRETINERE (0/blink/0): galben=1 on entry, toggles every T_BLINK ticks.
//  - Maintenance:
//    - intretinere=1 forces INTRETINERE next cycle from any state; it has priority over all transitions.
//    - PREDARE is aborted, so no token is emitted.
//    - intretinere=0 -> ASTEAPTA with pending=0. The ring restarts only via a new token edge.
//  - Outside INTRETINERE exactly one lamp is lit. continuare_out is never high for 2 consecutive cycles.
//  - Reset mid-phase returns immediately to the reset values; the prescaler phase is lost.
// TESTING
//  Bench parameters: SEC=4, T_GARDA=1, T_GALBEN=2, T_VERDE=3, T_BLINK=1, HAS_TOKEN=0.
//  1. Reset, no token for 100 cycles -> rosu=1 steady, continuare_out never 1.
//  2. continuare_in 0->1 at cycle k:
//     - rosu 4 cycles, galben 8 cycles, verde 12 cycles;
//     - then rosu with continuare_out=1 for 1 cycle; then rosu idle.
//  3. Second edge during VERDE -> after PREDARE plus 1 cycle in ASTEAPTA, a new GARDA starts immediately.
//     A held-high continuare_in produces no extra token.
//  4. intretinere=1 during GALBEN:
//     - next cycle galben=1, rosu=verde=0;
//     - galben toggles every 4 cycles;
//     - release -> rosu=1, waits for a fresh edge.
//  5. intretinere asserted on the PREDARE cycle -> continuare_out stays 0.
//     Token edges during maintenance are ignored after release.
//  6. HAS_TOKEN=1: release reset -> GARDA starts at the first clock, full sequence runs without an input edge.
//     reset pulsed low mid-VERDE -> rosu=1 asynchronously.

Source files
------------

// File: rtl/semafor_directie_param.sv
// One-approach traffic light for a token-ring intersection.
// Waits for the token, runs clearance/yellow/green, passes the token on.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low
//   intretinere    maintenance request (level), forces blinking yellow
//   continuare_in  token from previous approach, rising edge = token
//   continuare_out token to next approach, one-cycle pulse
//   verde/galben/rosu  lamps, registered, lag the state by one cycle
module semafor_directie_param #(
  parameter logic [23:0] SEC       = 24'd10000000,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned T_GARDA   = 1,
  parameter int unsigned T_GALBEN  = 2,
  parameter int unsigned T_VERDE   = 26,
  parameter int unsigned T_BLINK   = 1,
  parameter bit          HAS_TOKEN = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic intretinere,
  input  logic continuare_in,
  output logic continuare_out,
  output logic verde,
  output logic galben,
  output logic rosu
);

  typedef enum logic [2:0] {
    ASTEAPTA,
    GARDA,
    GALBEN,
    VERDE,
    PREDARE,
    INTRETINERE
  } state_t;

  // Last timer value of a phase; a zero duration behaves as one tick.
  function automatic logic [CNT_W-1:0] lim(input int unsigned t);
    return (t == 0) ? '0 : CNT_W'(t - 1);
  endfunction

  localparam logic [23:0]      SEC_M1   = SEC - 24'd1;
  localparam logic [CNT_W-1:0] L_GARDA  = lim(T_GARDA);
  localparam logic [CNT_W-1:0] L_GALBEN = lim(T_GALBEN);
  localparam logic [CNT_W-1:0] L_VERDE  = lim(T_VERDE);
  localparam logic [CNT_W-1:0] L_BLINK  = lim(T_BLINK);

  state_t           state;
  logic [23:0]      presc;
  logic [CNT_W-1:0] timer;
  logic             prev_in;
  logic             pending;
  logic             blink;

  logic tick;
  logic tok_edge;
  logic done;

  always_comb begin
    tick     = (presc == SEC_M1);
    tok_edge = continuare_in & ~prev_in;
    done     = 1'b0;
    unique case (state)
      GARDA:       done = tick && (timer == L_GARDA);
      GALBEN:      done = tick && (timer == L_GALBEN);
      VERDE:       done = tick && (timer == L_VERDE);
      INTRETINERE: done = tick && (timer == L_BLINK);
      default:     done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ASTEAPTA;
      presc          <= '0;
      timer          <= '0;
      prev_in        <= 1'b0;
      pending        <= HAS_TOKEN;
      blink          <= 1'b0;
      rosu           <= 1'b1;
      galben         <= 1'b0;
      verde          <= 1'b0;
      continuare_out <= 1'b0;
    end else begin
      prev_in <= continuare_in;
      presc   <= tick ? '0 : presc + 24'd1;
      if (tick) timer <= timer + CNT_W'(1);

      // Lamps decode the current state; a maintenance request
      // suppresses the token pulse of an aborted handover.
      rosu   <= state inside {ASTEAPTA, GARDA, PREDARE};
      galben <= (state == GALBEN) ||
                ((state == INTRETINERE) && blink);
      verde  <= (state == VERDE);
      continuare_out <= (state == PREDARE) && !intretinere;

      if (tok_edge && state != INTRETINERE) pending <= 1'b1;

      if (intretinere) begin
        if (state != INTRETINERE) begin
          state <= INTRETINERE;
          presc <= '0;
          timer <= '0;
          blink <= 1'b1;
        end else if (done) begin
          timer <= '0;
          blink <= ~blink;
        end
      end else begin
        unique case (state)
          ASTEAPTA: if (pending) begin
            state   <= GARDA;
            presc   <= '0;
            timer   <= '0;
            // a token arriving now is kept for the next round
            pending <= tok_edge;
          end
          GARDA: if (done) begin
            state <= GALBEN;
            presc <= '0;
            timer <= '0;
          end
          GALBEN: if (done) begin
            state <= VERDE;
            presc <= '0;
            timer <= '0;
          end
          VERDE: if (done) begin
            state <= PREDARE;
            presc <= '0;
            timer <= '0;
          end
          PREDARE: begin
            state <= ASTEAPTA;
            presc <= '0;
            timer <= '0;
          end
          INTRETINERE: begin
            state   <= ASTEAPTA;
            presc   <= '0;
            timer   <= '0;
            pending <= 1'b0;
          end
          default: state <= ASTEAPTA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_semafor_directie_param.sv
// Bench for semafor_directie_param: table vectors, directed
// corner sequences and random stimulus against a phase model.
module tb_semafor_directie_param;

  localparam int S   = 4;
  localparam int TG  = 1;
  localparam int TY  = 2;
  localparam int TV  = 3;
  localparam int TBL = 1;

  localparam int IDLE = 0;
  localparam int GAR  = 1;
  localparam int YEL  = 2;
  localparam int GRN  = 3;
  localparam int HND  = 4;
  localparam int MNT  = 5;

  typedef struct {
    int ph;
    int rem;
    bit pend;
    bit prev;
    bit blink;
  } mdl_t;

  typedef struct {
    bit          mnt;
    bit          cin;
    int          n;
    logic [3:0]  exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst1, rst2;
  logic mnt, cin;
  logic zero = 1'b0;
  logic co1, verde1, galben1, rosu1;
  logic co2, verde2, galben2, rosu2;

  int n_tests = 0;
  int n_fail  = 0;
  int sn      = 0;

  mdl_t m1, m2;
  logic [3:0] e1, e2;

  always #5 clk = ~clk;

  semafor_directie_param #(
    .SEC(24'd4), .CNT_W(8), .T_GARDA(TG), .T_GALBEN(TY),
    .T_VERDE(TV), .T_BLINK(TBL), .HAS_TOKEN(1'b0)
  ) dut1 (
    .clk(clk), .reset(rst1), .intretinere(mnt),
    .continuare_in(cin), .continuare_out(co1),
    .verde(verde1), .galben(galben1), .rosu(rosu1)
  );

  semafor_directie_param #(
    .SEC(24'd4), .CNT_W(8), .T_GARDA(TG), .T_GALBEN(TY),
    .T_VERDE(TV), .T_BLINK(TBL), .HAS_TOKEN(1'b1)
  ) dut2 (
    .clk(clk), .reset(rst2), .intretinere(zero),
    .continuare_in(zero), .continuare_out(co2),
    .verde(verde2), .galben(galben2), .rosu(rosu2)
  );

  function automatic mdl_t mreset(input bit tok);
    mdl_t m;
    m.ph = IDLE; m.rem = 0; m.pend = tok;
    m.prev = 1'b0; m.blink = 1'b0;
    return m;
  endfunction

  // {rosu, galben, verde, continuare_out} produced for a phase
  function automatic logic [3:0] mout(input mdl_t m, input bit mi);
    logic r, y, g, c;
    r = (m.ph == IDLE) || (m.ph == GAR) || (m.ph == HND);
    y = (m.ph == YEL) || (m.ph == MNT && m.blink);
    g = (m.ph == GRN);
    c = (m.ph == HND) && !mi;
    return {r, y, g, c};
  endfunction

  // Each timed phase counts down DUR*SEC clock cycles.
  function automatic mdl_t mnext(input mdl_t m, input bit mi,
                                 input bit ci);
    bit e;
    e = ci & ~m.prev;
    m.prev = ci;
    if (mi) begin
      if (m.ph != MNT) begin
        m.ph = MNT; m.rem = TBL * S; m.blink = 1'b1;
      end else begin
        m.rem--;
        if (m.rem == 0) begin
          m.blink = !m.blink; m.rem = TBL * S;
        end
      end
      return m;
    end
    case (m.ph)
      IDLE: begin
        if (m.pend) begin m.ph = GAR; m.rem = TG * S; end
        m.pend = e;
      end
      GAR, YEL, GRN: begin
        m.pend = m.pend | e;
        m.rem--;
        if (m.rem == 0) begin
          if (m.ph == GAR) begin m.ph = YEL; m.rem = TY * S; end
          else if (m.ph == YEL) begin m.ph = GRN; m.rem = TV * S; end
          else m.ph = HND;
        end
      end
      HND: begin m.pend = m.pend | e; m.ph = IDLE; end
      default: begin m.ph = IDLE; m.pend = 1'b0; end
    endcase
    return m;
  endfunction

  task automatic check(input string nm, input logic [3:0] got,
                       input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got rygc=%b expected %b",
               nm, sn, got, exp);
    end
  endtask

  task automatic step(input bit mi, input bit ci);
    mnt = mi;
    cin = ci;
    @(posedge clk);
    e1 = mout(m1, mi);
    m1 = mnext(m1, mi, ci);
    e2 = mout(m2, 1'b0);
    m2 = mnext(m2, 1'b0, 1'b0);
    @(negedge clk);
    sn++;
    check("model1", {rosu1, galben1, verde1, co1}, e1);
    check("model2", {rosu2, galben2, verde2, co2}, e2);
  endtask

  initial begin
    vec_t tbl[7];
    bit rm, rc;

    tbl[0] = '{1'b0, 1'b0, 100, 4'b1000, "idle"};
    tbl[1] = '{1'b0, 1'b1, 1,   4'b1000, "edge"};
    tbl[2] = '{1'b0, 1'b1, 5,   4'b1000, "garda"};
    tbl[3] = '{1'b0, 1'b1, 8,   4'b0100, "galben"};
    tbl[4] = '{1'b0, 1'b1, 12,  4'b0010, "verde"};
    tbl[5] = '{1'b0, 1'b1, 1,   4'b1001, "predare"};
    tbl[6] = '{1'b0, 1'b0, 3,   4'b1000, "after"};

    rst1 = 1'b0; rst2 = 1'b0; mnt = 1'b0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset1", {rosu1, galben1, verde1, co1}, 4'b1000);
    check("reset2", {rosu2, galben2, verde2, co2}, 4'b1000);
    m1 = mreset(1'b0);
    m2 = mreset(1'b1);
    rst1 = 1'b1; rst2 = 1'b1;

    // ring starter runs without an input edge
    for (int s = 1; s <= 20; s++) begin
      step(1'b0, 1'b0);
      if (s == 5)  check("start_red", {rosu2, galben2, verde2, co2}, 4'b1000);
      if (s == 6)  check("start_yel", {rosu2, galben2, verde2, co2}, 4'b0100);
      if (s == 20) check("start_grn", {rosu2, galben2, verde2, co2}, 4'b0010);
    end
    #2 rst2 = 1'b0;
    #1 check("async_rst", {rosu2, galben2, verde2, co2}, 4'b1000);
    m2 = mreset(1'b1);
    #1 rst2 = 1'b1;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].mnt, tbl[i].cin);
        check(tbl[i].name, {rosu1, galben1, verde1, co1}, tbl[i].exp);
      end
    end

    // second token during green, input then held high
    for (int s = 1; s <= 62; s++) begin
      step(1'b0, s != 17);
      if (s == 27) check("pulse1", {rosu1, galben1, verde1, co1}, 4'b1001);
      if (s == 28) check("wait1", {rosu1, galben1, verde1, co1}, 4'b1000);
      if (s == 33) check("regarda", {rosu1, galben1, verde1, co1}, 4'b0100);
      if (s == 53) check("pulse2", {rosu1, galben1, verde1, co1}, 4'b1001);
      if (s == 62) check("no_extra", {rosu1, galben1, verde1, co1}, 4'b1000);
    end

    // maintenance during yellow
    for (int s = 0; s <= 45; s++) begin
      step(s >= 10 && s <= 20, s >= 1 && s <= 3);
      if (s == 11) check("blink_on", {rosu1, galben1, verde1, co1}, 4'b0100);
      if (s == 15) check("blink_off", {rosu1, galben1, verde1, co1}, 4'b0000);
      if (s == 18) check("blink_off2", {rosu1, galben1, verde1, co1}, 4'b0000);
      if (s == 19) check("blink_on2", {rosu1, galben1, verde1, co1}, 4'b0100);
      if (s == 22) check("release", {rosu1, galben1, verde1, co1}, 4'b1000);
      if (s == 45) check("no_restart", {rosu1, galben1, verde1, co1}, 4'b1000);
    end

    // maintenance on the handover cycle, edges inside maintenance
    for (int s = 0; s <= 70; s++) begin
      step(s >= 27 && s <= 35,
           (s >= 1 && s <= 5) || s == 30 || (s >= 32));
      if (s == 26) check("last_grn", {rosu1, galben1, verde1, co1}, 4'b0010);
      if (s == 27) check("abort_tok", {rosu1, galben1, verde1, co1}, 4'b1000);
      if (s == 28) check("mnt_entry", {rosu1, galben1, verde1, co1}, 4'b0100);
      if (s == 37) check("rel_red", {rosu1, galben1, verde1, co1}, 4'b1000);
      if (s == 70) check("edges_drop", {rosu1, galben1, verde1, co1}, 4'b1000);
    end

    rm = 1'b0; rc = 1'b0;
    for (int s = 0; s < 4000; s++) begin
      if ($urandom_range(0, 199) == 0) rm = !rm;
      if ($urandom_range(0, 19) == 0) rc = !rc;
      step(rm, rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
